// File: rtl/lcd_char_writer.sv
// HD44780 16x2 character writer in 8-bit mode: power-up init, E-strobe timing, cursor wrap, clear.
// Build option LCD_DEDUP_EN: an accepted character equal to the last written data byte is dropped.
module lcd_char_writer #(
  parameter int unsigned POWERUP_CYC  = 750000,
  parameter int unsigned SETUP_CYC    = 4,
  parameter int unsigned E_PULSE_CYC  = 25,
  parameter int unsigned CMD_WAIT_CYC = 2500,
  parameter int unsigned CLR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  input  logic       clr,
  output logic       char_ready,
  output logic       init_done,
  output logic       cursor_line,
  output logic [3:0] cursor_col,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  localparam int unsigned MAX_A   = (POWERUP_CYC > CLR_WAIT_CYC) ? POWERUP_CYC : CLR_WAIT_CYC;
  localparam int unsigned MAX_B   = (CMD_WAIT_CYC > E_PULSE_CYC) ? CMD_WAIT_CYC : E_PULSE_CYC;
  localparam int unsigned MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int          CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, IDLE, XFER_SETUP, XFER_PULSE, XFER_WAIT, WRAP
  } state_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             init_done_q, init_done_d;
  logic             line_q, line_d;
  logic [3:0]       col_q, col_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;

  logic             issue;
  logic             issue_rs;
  logic [7:0]       issue_data;
  state_t           issue_ret;
  logic [CNT_W-1:0] wait_last;
  logic             is_nl;
  logic [7:0]       mapped;
  logic             dup;

  assign is_nl  = (char_in == 8'h0A);
  assign mapped = (char_in < 8'h20 || char_in > 8'h7E) ? 8'h20 : char_in;

`ifdef LCD_DEDUP_EN
  logic [7:0] last_q, last_d;
  logic       last_vld_q, last_vld_d;

  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (state_q == IDLE) begin
      if (clr) begin
        last_vld_d = 1'b0;
      end else if (char_valid && !is_nl) begin
        last_d     = mapped;
        last_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign dup = last_vld_q && (last_q == mapped);
`else
  assign dup = 1'b0;
`endif

  // Handshake: char_in is consumed on a rising clk edge where char_valid && char_ready.
  assign char_ready  = (state_q == IDLE) && !clr;
  assign init_done   = init_done_q;
  assign cursor_line = line_q;
  assign cursor_col  = col_q;
  assign lcd_e       = e_q;
  assign lcd_rs      = rs_q;
  assign lcd_rw      = 1'b0;
  assign lcd_data    = data_q;

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    line_d      = line_q;
    col_d       = col_q;
    e_d         = e_q;
    rs_d        = rs_q;
    data_d      = data_q;
    issue       = 1'b0;
    issue_rs    = 1'b0;
    issue_data  = '0;
    issue_ret   = IDLE;
    // The clear command needs the long settle time, whoever issued it.
    wait_last   = (!rs_q && data_q == 8'h01) ? CLR_LAST : CMD_LAST;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          issue      = 1'b1;
          issue_data = init_cmd(idx_q);
          issue_ret  = INIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      INIT: begin
        issue      = 1'b1;
        issue_data = init_cmd(idx_q);
        issue_ret  = INIT;
      end
      IDLE: begin
        if (clr) begin
          issue      = 1'b1;
          issue_data = 8'h01;
          line_d     = 1'b0;
          col_d      = '0;
        end else if (char_valid) begin
          if (is_nl) begin
            issue      = 1'b1;
            issue_data = line_q ? 8'h80 : 8'hC0;
            line_d     = ~line_q;
            col_d      = '0;
          end else if (!dup) begin
            issue      = 1'b1;
            issue_rs   = 1'b1;
            issue_data = mapped;
            col_d      = col_q + 1'b1;
            issue_ret  = (col_q == 4'hF) ? WRAP : IDLE;
          end
        end
      end
      XFER_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          e_d     = 1'b1;
          state_d = XFER_PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      XFER_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          e_d     = 1'b0;
          state_d = XFER_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      XFER_WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d = '0;
          case (ret_q)
            INIT: begin
              // Init commands run back to back; the last one hands over to IDLE.
              if (idx_q == 2'd3) begin
                state_d     = IDLE;
                init_done_d = 1'b1;
                line_d      = 1'b0;
                col_d       = '0;
              end else begin
                idx_d      = idx_q + 2'd1;
                issue      = 1'b1;
                issue_data = init_cmd(idx_q + 2'd1);
                issue_ret  = INIT;
              end
            end
            WRAP:    state_d = WRAP;
            default: state_d = IDLE;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRAP: begin
        issue      = 1'b1;
        issue_data = line_q ? 8'h80 : 8'hC0;
        line_d     = ~line_q;
        col_d      = '0;
      end
      default: state_d = PWR_WAIT;
    endcase

    if (issue) begin
      state_d = XFER_SETUP;
      ret_d   = issue_ret;
      cnt_d   = '0;
      rs_d    = issue_rs;
      data_d  = issue_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PWR_WAIT;
      ret_q       <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      line_q      <= 1'b0;
      col_q       <= '0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      line_q      <= line_d;
      col_q       <= col_d;
      e_q         <= e_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_lcd_char_writer.sv
// Scoreboard bench for lcd_char_writer: expected LCD transfers queued by a reference model,
// checked by a monitor on every E pulse; latency and cursor checked after each request.
module tb_lcd_char_writer;

  localparam int POWERUP  = 20;
  localparam int SETUP    = 2;
  localparam int PULSE    = 4;
  localparam int CMDW     = 8;
  localparam int CLRW     = 30;
  localparam int XFER_CYC = SETUP + PULSE + CMDW;
  localparam int CLR_CYC  = SETUP + PULSE + CLRW;
  localparam int INIT_CYC = POWERUP + 3 * XFER_CYC + CLR_CYC;
  localparam logic [7:0] INIT_SEQ [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  logic       clk;
  logic       reset;
  logic [7:0] char_in;
  logic       char_valid;
  logic       clr;
  logic       char_ready;
  logic       init_done;
  logic       cursor_line;
  logic [3:0] cursor_col;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  lcd_char_writer #(
    .POWERUP_CYC (POWERUP),
    .SETUP_CYC   (SETUP),
    .E_PULSE_CYC (PULSE),
    .CMD_WAIT_CYC(CMDW),
    .CLR_WAIT_CYC(CLRW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .clr        (clr),
    .char_ready (char_ready),
    .init_done  (init_done),
    .cursor_line(cursor_line),
    .cursor_col (cursor_col),
    .lcd_e      (lcd_e),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_data   (lcd_data)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard state: {rs, data} of each transfer the display should see
  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  // Reference model: cursor position and (optionally) last written byte
  int m_line;
  int m_col;
`ifdef LCD_DEDUP_EN
  logic [7:0] m_last;
  logic       m_last_vld;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] map_char(input logic [7:0] c);
    return (c < 8'h20 || c > 8'h7E) ? 8'h20 : c;
  endfunction

  // kind: 0 = consumed without transfer, 1 = one transfer, 2 = data plus wrap command
  task automatic model_char(input logic [7:0] c, output int kind);
    logic [7:0] m;
    if (c == 8'h0A) begin
      exp_q.push_back({1'b0, (m_line == 1) ? 8'h80 : 8'hC0});
      m_line = 1 - m_line;
      m_col  = 0;
      kind   = 1;
    end else begin
      m = map_char(c);
`ifdef LCD_DEDUP_EN
      if (m_last_vld && m == m_last) begin
        kind = 0;
        return;
      end
      m_last     = m;
      m_last_vld = 1'b1;
`endif
      exp_q.push_back({1'b1, m});
      if (m_col == 15) begin
        exp_q.push_back({1'b0, (m_line == 1) ? 8'h80 : 8'hC0});
        m_line = 1 - m_line;
        m_col  = 0;
        kind   = 2;
      end else begin
        m_col++;
        kind = 1;
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_line = 0;
    m_col  = 0;
`ifdef LCD_DEDUP_EN
    m_last_vld = 1'b0;
`endif
  endtask

  // Monitor: pops one expected transfer per E rising edge, checks E width
  logic prev_e = 1'b0;
  int   e_width = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_e  = 1'b0;
      e_width = 0;
    end else begin
      if (lcd_e && !prev_e) begin
        check("pulse_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("xfer_rs_data", {lcd_rs, lcd_data}, exp_q.pop_front());
        check("lcd_rw", lcd_rw, 0);
      end
      if (lcd_e) e_width++;
      if (!lcd_e && prev_e) begin
        check("e_width", e_width, PULSE);
        e_width = 0;
      end
      prev_e = lcd_e;
    end
  end

  // Driver tasks
  task automatic check_cursor();
    check("cursor_line", cursor_line, m_line);
    check("cursor_col", cursor_col, m_col);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lcd_e"}, lcd_e, 0);
    check({tag, "_lcd_rs"}, lcd_rs, 0);
    check({tag, "_lcd_rw"}, lcd_rw, 0);
    check({tag, "_lcd_data"}, lcd_data, 0);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_char_ready"}, char_ready, 0);
    check({tag, "_cursor_line"}, cursor_line, 0);
    check({tag, "_cursor_col"}, cursor_col, 0);
  endtask

  task automatic wait_ready(output bit ok);
    int g = 0;
    while (!char_ready && g < 3000) begin
      @(negedge clk);
      g++;
    end
    ok = char_ready;
    if (!ok) check("ready_wait", char_ready, 1);
  endtask

  task automatic release_and_init();
    int cycles;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, INIT_SEQ[i]});
    @(negedge clk);
    reset = 1'b0;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!init_done && cycles < 500);
    check("init_done_cycles", cycles, INIT_CYC);
    check("init_queue_drained", exp_q.size(), 0);
    check("init_char_ready", char_ready, 1);
    check_cursor();
  endtask

  task automatic send_char(input logic [7:0] c);
    int kind, cycles, e_first;
    bit ok;
    @(negedge clk);
    wait_ready(ok);
    if (!ok) return;
    char_in    = c;
    char_valid = 1'b1;
    model_char(c, kind);
    @(negedge clk);
    char_valid = 1'b0;
    cycles  = 0;
    e_first = 0;
    while (!char_ready && cycles < 3000) begin
      cycles++;
      if (lcd_e && e_first == 0) e_first = cycles;
      @(negedge clk);
    end
    if (kind == 2) begin
      check("wrap_ready_min", cycles >= 2 * XFER_CYC, 1);
      check("wrap_ready_max", cycles <= 2 * XFER_CYC + 1, 1);
    end else begin
      check("ready_latency", cycles, (kind == 0) ? 0 : XFER_CYC);
    end
    check("e_rise_delay", e_first, (kind == 0) ? 0 : SETUP + 1);
    check_cursor();
  endtask

  task automatic do_clr();
    int cycles;
    bit ok;
    @(negedge clk);
    wait_ready(ok);
    if (!ok) return;
    clr        = 1'b1;
    char_valid = 1'b1;
    char_in    = 8'($urandom_range(8'h21, 8'h7E));
    exp_q.push_back({1'b0, 8'h01});
    m_line = 0;
    m_col  = 0;
`ifdef LCD_DEDUP_EN
    m_last_vld = 1'b0;
`endif
    @(negedge clk);
    clr        = 1'b0;
    char_valid = 1'b0;
    cycles = 0;
    while (!char_ready && cycles < 3000) begin
      cycles++;
      @(negedge clk);
    end
    check("clr_ready_low", cycles, CLR_CYC);
    check_cursor();
  endtask

  // Stimulus
  initial begin
    logic [7:0] r8;
    int g;
    bit ok;
    reset      = 1'b1;
    char_valid = 1'b0;
    clr        = 1'b0;
    char_in    = 8'h00;
    m_line     = 0;
    m_col      = 0;
`ifdef LCD_DEDUP_EN
    m_last_vld = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    release_and_init();

    send_char(8'h50);
    do_clr();

    for (int i = 0; i < 16; i++) send_char(8'(8'h41 + i));
    for (int i = 0; i < 16; i++) begin
      r8 = 8'($urandom_range(0, 255));
      if (r8 == 8'h0A) r8 = 8'h0B;
      send_char(r8);
    end

    do_clr();
    send_char(8'h0A);
    send_char(8'h07);
    send_char(8'h50);
    send_char(8'h50);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       do_clr();
        1:       send_char(8'h0A);
        2, 3:    send_char(8'($urandom_range(0, 255)));
        4:       send_char(char_in);
        default: send_char(8'($urandom_range(8'h20, 8'h7E)));
      endcase
    end

    // Reset in the middle of an E pulse
    do_clr();
    @(negedge clk);
    wait_ready(ok);
    if (ok) begin
      char_in    = 8'h51;
      char_valid = 1'b1;
      exp_q.push_back({1'b1, 8'h51});
      @(negedge clk);
      char_valid = 1'b0;
      g = 0;
      while (!lcd_e && g < 100) begin
        @(negedge clk);
        g++;
      end
      check("e_seen_before_reset", lcd_e, 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_outputs("mid_reset");
      model_reset();
      repeat (2) @(negedge clk);
      release_and_init();
    end
    send_char(8'h5A);

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
